// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage branch/jump comparator plus a direct-mapped 2-bit BHT read by fetch.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters with a synchronous clear.
`ifndef BJ_OP_BUS
`define BJ_OP_BUS 3:0
`endif
`ifndef EXE_BJOP_NOOP
`define EXE_BJOP_NOOP 4'd0
`define EXE_BJOP_JUMP 4'd1
`define EXE_BJOP_BEQ  4'd2
`define EXE_BJOP_BNE  4'd3
`define EXE_BJOP_BLT  4'd4
`define EXE_BJOP_BGE  4'd5
`define EXE_BJOP_BLTU 4'd6
`define EXE_BJOP_BGEU 4'd7
`endif

module branch_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int BHT_DEPTH  = 64,
  localparam int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BRU_STATS_EN
  input  logic              stats_clr,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
`endif
  input  logic              pred_valid,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  output logic              pred_out_valid,
  input  logic              res_valid,
  input  logic [`BJ_OP_BUS] bj_op,
  input  logic [XLEN-1:0]   rrd1,
  input  logic [XLEN-1:0]   rrd2,
  input  logic [XLEN-1:0]   res_pc,
  input  logic              res_pred_taken,
  output logic              b_taken,
  output logic              mispredict,
  output logic              bj_illegal,
  output logic              res_out_valid
);

  logic [1:0]           bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] pred_idx;
  logic [BHT_IDX_W-1:0] res_idx;
  logic                 cmp;
  logic                 op_cond;
  logic                 op_ill;
  logic                 upd_en;
  logic [1:0]           cur_ctr;
  logic [1:0]           upd_ctr;
  logic                 pred_bit;
  logic                 mis_cond;
  logic                 unused_pc_bits;

  // Word-aligned PCs: bits [1:0] and everything above the index are dropped (no tags).
  assign pred_idx       = pred_pc[BHT_IDX_W+1:2];
  assign res_idx        = res_pc[BHT_IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc, res_pc};

  always_comb begin
    cmp     = 1'b0;
    op_cond = 1'b0;
    op_ill  = 1'b0;
    case (bj_op)
      `EXE_BJOP_NOOP: cmp = 1'b0;
      `EXE_BJOP_JUMP: cmp = 1'b1;
      `EXE_BJOP_BEQ:  begin cmp = (rrd1 == rrd2);                   op_cond = 1'b1; end
      `EXE_BJOP_BNE:  begin cmp = (rrd1 != rrd2);                   op_cond = 1'b1; end
      `EXE_BJOP_BLT:  begin cmp = ($signed(rrd1) <  $signed(rrd2)); op_cond = 1'b1; end
      `EXE_BJOP_BGE:  begin cmp = ($signed(rrd1) >= $signed(rrd2)); op_cond = 1'b1; end
      `EXE_BJOP_BLTU: begin cmp = (rrd1 <  rrd2);                   op_cond = 1'b1; end
      `EXE_BJOP_BGEU: begin cmp = (rrd1 >= rrd2);                   op_cond = 1'b1; end
      default:        op_ill = 1'b1;
    endcase
  end

  assign upd_en   = res_valid & op_cond;
  assign cur_ctr  = bht[res_idx];
  assign mis_cond = res_valid & (cmp ^ res_pred_taken);

  always_comb begin
    upd_ctr = cur_ctr;
    if (cmp) begin
      if (cur_ctr != 2'b11) upd_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) upd_ctr = cur_ctr - 2'b01;
    end
  end

  // Same-cycle write to the entry being predicted is forwarded to fetch.
  assign pred_bit = (upd_en && (pred_idx == res_idx)) ? upd_ctr[1] : bht[pred_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      pred_taken     <= 1'b0;
      pred_out_valid <= 1'b0;
      b_taken        <= 1'b0;
      mispredict     <= 1'b0;
      bj_illegal     <= 1'b0;
      res_out_valid  <= 1'b0;
    end else begin
      if (upd_en) bht[res_idx] <= upd_ctr;
      if (pred_valid) pred_taken <= pred_bit;
      pred_out_valid <= pred_valid;
      res_out_valid  <= res_valid;
      b_taken        <= res_valid & cmp;
      mispredict     <= mis_cond;
      bj_illegal     <= res_valid & op_ill;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && (bj_op != `EXE_BJOP_NOOP) && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mis_cond && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
